// File: rtl/seg_scan_receiver_if.sv
// Scan-bus and frame-report bundle for seg_scan_receiver.
// Latency: none (wiring only).
// Backpressure: none; the scan bus is free-running and frames are reported as pulses.
//
// Signals:
//   an[3:0]        anode select, active-low one-hot (1110 = digit0 .. 0111 = digit3)
//   num[6:0]       segment pattern {g,f,e,d,c,b,a}, bit0 = a
//   digit0..3      last published decoded value per digit
//   dig_blank      per-digit flag, pattern was all-off
//   dig_err        per-digit flag, pattern was neither a hex glyph nor blank
//   frame_valid    one-cycle pulse per published frame
//   frame_changed  one-cycle pulse with frame_valid when the frame differs from the previous one
//   anode_err      one-cycle pulse on an illegal anode pattern
//   signal_lost    level, no frame completed within the timeout window
//
// master: the scan driver / monitor side.  slave: the receiver.
interface seg_scan_receiver_if;
  logic [3:0] an;
  logic [6:0] num;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dig_blank;
  logic [3:0] dig_err;
  logic       frame_valid;
  logic       frame_changed;
  logic       anode_err;
  logic       signal_lost;

  modport master (
    output an,
    output num,
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    input  dig_blank,
    input  dig_err,
    input  frame_valid,
    input  frame_changed,
    input  anode_err,
    input  signal_lost
  );

  modport slave (
    input  an,
    input  num,
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    output dig_blank,
    output dig_err,
    output frame_valid,
    output frame_changed,
    output anode_err,
    output signal_lost
  );
endinterface

// File: rtl/seg_scan_receiver.sv
// Demultiplexes a 4-digit 7-segment scan bus, decodes each digit and publishes whole frames.
// Latency: sample at edge N -> slot written at N+1 -> frame outputs/frame_valid after N+2.
// Backpressure: none; every scan sample is consumed, including one arriving during publish.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset (wins over everything else)
//   bus    seg_scan_receiver_if.slave: an/num in; digit0..3, dig_blank, dig_err,
//          frame_valid, frame_changed, anode_err, signal_lost out
//
// Parameters:
//   SEG_ACTIVE_LOW  1 = segment bits are inverted before decoding
//   TIMEOUT_CYC     cycles without a published frame before signal_lost (8..65535)
module seg_scan_receiver #(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned TIMEOUT_CYC    = 1024
) (
  input logic            clk,
  input logic            reset,
  seg_scan_receiver_if.slave bus
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  // stage 1: registered copy of the raw bus
  logic [3:0] an_q;
  logic [6:0] num_q;

  // stage 2: classification and decode of the registered sample
  logic [6:0] seg;
  logic [3:0] dec_val;
  logic       dec_blank;
  logic       dec_err;
  logic       wr;
  logic [1:0] wr_idx;
  logic [3:0] wr_mask;
  logic       bad_an;

  // frame assembly
  logic [3:0] slot_val [4];
  logic [3:0] slot_blank;
  logic [3:0] slot_err;
  logic [3:0] seen;
  logic [3:0] seen_nxt;
  state_t     state;
  state_t     state_nxt;
  logic       publish;
  logic       frame_diff;

  // timeout
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_hit;

  // output registers; the published frame doubles as the previous-frame copy
  logic [3:0] dig_q [4];
  logic [3:0] blank_q;
  logic [3:0] err_q;
  logic       fv_q;
  logic       fc_q;
  logic       ae_q;
  logic       lost_q;

  // ---------------------------------------------------------------- stage 2
  always_comb begin
    wr      = 1'b0;
    wr_idx  = 2'd0;
    wr_mask = 4'b0000;
    bad_an  = 1'b0;
    case (an_q)
      4'b1110: begin wr = 1'b1; wr_idx = 2'd0; wr_mask = 4'b0001; end
      4'b1101: begin wr = 1'b1; wr_idx = 2'd1; wr_mask = 4'b0010; end
      4'b1011: begin wr = 1'b1; wr_idx = 2'd2; wr_mask = 4'b0100; end
      4'b0111: begin wr = 1'b1; wr_idx = 2'd3; wr_mask = 4'b1000; end
      // all anodes off (blanked) or all on (driver held in reset): idle
      4'b1111, 4'b0000: ;
      default: bad_an = 1'b1;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~num_q : num_q;

  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- timeout
  assign publish = (state == PUBLISH);

  always_comb begin
    cnt_nxt = cnt;
    if (publish) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // fires once, on the cycle the counter first reaches the limit; the
  // saturated counter must not keep wiping the mask or recovery is impossible
  assign timeout_hit = !publish && (cnt != CNT_MAX) && (cnt_nxt == CNT_MAX);

  // ---------------------------------------------------------------- seen mask
  // Publish, an illegal anode and a timeout each discard the partial frame;
  // the current sample is still merged in so a slot arriving during publish
  // starts the next frame.
  always_comb begin
    seen_nxt = seen;
    if (publish || bad_an || timeout_hit) begin
      seen_nxt = 4'b0000;
    end
    seen_nxt = seen_nxt | wr_mask;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = COLLECT;
    case (state)
      COLLECT: state_nxt = (seen_nxt == 4'b1111) ? PUBLISH : COLLECT;
      PUBLISH: state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  assign frame_diff = ({slot_val[3], slot_val[2], slot_val[1], slot_val[0], slot_blank, slot_err}
                    != {dig_q[3], dig_q[2], dig_q[1], dig_q[0], blank_q, err_q});

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      an_q       <= 4'b1111;
      num_q      <= 7'h00;
      seen       <= 4'b0000;
      cnt        <= '0;
      slot_blank <= 4'b0000;
      slot_err   <= 4'b0000;
      blank_q    <= 4'b0000;
      err_q      <= 4'b0000;
      fv_q       <= 1'b0;
      fc_q       <= 1'b0;
      ae_q       <= 1'b0;
      lost_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        slot_val[k] <= 4'h0;
        dig_q[k]    <= 4'h0;
      end
    end else begin
      an_q  <= bus.an;
      num_q <= bus.num;
      seen  <= seen_nxt;
      cnt   <= cnt_nxt;

      // a revisit simply overwrites the slot; the mask bit is already set
      if (wr) begin
        slot_val[wr_idx]   <= dec_val;
        slot_blank[wr_idx] <= dec_blank;
        slot_err[wr_idx]   <= dec_err;
      end

      ae_q <= bad_an;
      fv_q <= publish;
      fc_q <= publish && frame_diff;

      // outputs take the pre-write slot contents, so a same-cycle write
      // belongs to the next frame
      if (publish) begin
        for (int k = 0; k < 4; k++) begin
          dig_q[k] <= slot_val[k];
        end
        blank_q <= slot_blank;
        err_q   <= slot_err;
        lost_q  <= 1'b0;
      end else if (timeout_hit) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign bus.digit0        = dig_q[0];
  assign bus.digit1        = dig_q[1];
  assign bus.digit2        = dig_q[2];
  assign bus.digit3        = dig_q[3];
  assign bus.dig_blank     = blank_q;
  assign bus.dig_err       = err_q;
  assign bus.frame_valid   = fv_q;
  assign bus.frame_changed = fc_q;
  assign bus.anode_err     = ae_q;
  assign bus.signal_lost   = lost_q;

endmodule

// File: doc/seg_scan_receiver.md
Name: seg_scan_receiver

Overview:
- Receive end of the multiplexed 4-digit 7-segment scan bus (anode select `an`, segment pattern `num`).
- Demultiplexes the time-shared bus, decodes each segment pattern to a 4-bit hex value and assembles complete 4-digit frames.
- Used as a display monitor/loopback checker in the alarm clock design and as a self-check capture block on the FPGA.

Parameters:
- SEG_ACTIVE_LOW, 0, 1 = segment bits are active-low and are inverted before decoding.
- TIMEOUT_CYC, 1024, cycles allowed without a frame completing before `signal_lost` asserts. Legal range 8..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- an  in  4  anode select, active-low one-hot (1110 = digit0, 1101 = digit1, 1011 = digit2, 0111 = digit3)
- num  in  7  segment pattern {g,f,e,d,c,b,a}; bit0 = a
- digit0  out  4  decoded value, digit 0
- digit1  out  4  decoded value, digit 1
- digit2  out  4  decoded value, digit 2
- digit3  out  4  decoded value, digit 3
- dig_blank  out  4  per-digit flag: pattern was all-off
- dig_err  out  4  per-digit flag: pattern was not decodable and not blank
- frame_valid  out  1  one-cycle pulse when a new frame is published
- frame_changed  out  1  one-cycle pulse, coincident with `frame_valid`, when any digit, blank or err bit differs from the previous published frame
- anode_err  out  1  one-cycle pulse on an illegal anode pattern
- signal_lost  out  1  level: no frame completed within TIMEOUT_CYC cycles

Behaviour:
- Reset (reset = 0 at a clk edge):
  - all digit outputs, `dig_blank`, `dig_err`, `frame_valid`, `frame_changed` and `anode_err` = 0; `signal_lost` = 0.
  - internal seen mask, slot registers, previous-frame copy and timeout counter cleared.
  - Reset wins over every other event in the same cycle.
- Stage 1, input register: `an` and `num` are registered every cycle. No other logic reads the raw inputs.
- Stage 2, classify/write: on the registered sample,
  - One-hot-low anode: decode the segment pattern (after optional inversion) into slot k, then set seen[k].
  - Anode 1111 or 0000: idle (blanked or driver in reset). No slot write, no error.
  - Any other anode pattern: `anode_err` pulses 1 cycle. No slot write. The seen mask is cleared, so a partial frame is discarded.
- Decode table (hex): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - 00 → value 0, blank = 1.
  - Any other pattern → value 0, err = 1.
- Revisits: if slot k is written again before the frame completes, the newer value overwrites the older one. The seen mask is unchanged.
- State machine:
  - COLLECT: wait until seen = 1111, counting the stage-2 write that completes the mask.
  - PUBLISH (exactly 1 cycle): copy all slots to the outputs atomically, pulse `frame_valid`, compute `frame_changed` against the previous frame, update the previous-frame copy, clear seen, return to COLLECT.
  - A stage-2 write arriving during PUBLISH is accepted into the cleared mask, so no scan slot is lost.
- Latency: sample on `an`/`num` at edge N → slot written at edge N+1 → if the frame completes, outputs and `frame_valid` are visible after edge N+2.
- The first published frame after reset asserts `frame_changed` only if it differs from the all-zero reset state.
- Timeout:
  - The counter increments every cycle and clears on each PUBLISH.
  - On reaching TIMEOUT_CYC, `signal_lost` = 1 and the seen mask is cleared. The counter saturates.
  - The next PUBLISH clears `signal_lost`. The counter width is derived from TIMEOUT_CYC.
- Digit outputs hold their last published values while `signal_lost` is high.

Test Plan:
- Scan sequence 1110/3F, 1101/06, 1011/5B, 0111/4F repeated, an/num changing every clk → `frame_valid` pulses every 4 cycles; digit0..3 = 0,1,2,3; first pulse has `frame_changed` = 1; later pulses have `frame_changed` = 0; first pulse appears 2 cycles after the 0111 sample.
- Same scan with digit2 pattern changed 5B→6D for one frame → one frame with digit2 = 5 and `frame_changed` = 1; the next frame shows digit2 = 2 and `frame_changed` = 1.
- Digit3 pattern 00, digit1 pattern 55 → `dig_blank` = 1000, `dig_err` = 0010, digit1 = 0, digit3 = 0.
- Anode 1100 injected after digit1 → `anode_err` pulses 1 cycle; no `frame_valid` until the next full 4-digit sweep.
- Stop the scan (an = 1111) for TIMEOUT_CYC = 16 cycles → `signal_lost` = 1 at cycle 16, digits held; resume the scan → `signal_lost` = 0 at the next `frame_valid`.
- Assert reset mid-frame after 3 digits, then release → all outputs 0; the first frame is published only after a full new 4-digit sweep.
